// File: rtl/mem_unit_if.sv
// mem_unit_if - 32-bit handshaked data-memory bus.
//
// One beat is offered by holding mem_req high with stable address, byte
// enables, write data and write enable; the memory side accepts it by raising
// mem_ack, and read data is valid in that same cycle.
//
// Signals:
//   mem_req    master -> slave  beat request
//   mem_we     master -> slave  1 = write beat, 0 = read beat
//   mem_addr   master -> slave  word-aligned byte address (AW bits)
//   mem_be     master -> slave  byte-lane enables, bit i = bits [8i+7:8i]
//   mem_wdata  master -> slave  write data
//   mem_ack    slave -> master  beat accepted / read data valid
//   mem_rdata  slave -> master  read data
interface mem_unit_if #(
  parameter int AW = 32
);

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic [31:0]   mem_rdata;

  // The load/store unit drives the request side.
  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_be,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  // The memory answers with ack and read data.
  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_be,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/mem_unit.sv
// mem_unit - load/store unit of the CPU data path.
//
// Accepts one load or store command at a time and runs it on the 32-bit
// handshaked memory bus (mem_unit_if). Byte and word accesses take one beat;
// doubleword accesses take two beats (low word first). Load data is returned
// raw and zero-extended; sign extension is left to the writeback selector.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   command strobe, only looked at while idle
//   we       in   1 = store, 0 = load
//   sz       in   00 byte, 10 word, 11 doubleword, 01 reserved
//   addr     in   byte address (AW bits)
//   st_data  in   store data (low 8/32/64 bits used by size)
//   busy     out  high whenever the unit is not idle
//   done     out  one-cycle completion pulse
//   err      out  with done: misaligned address or reserved size
//   ld_data  out  load result, held until the next load completes
//   bus      mem_unit_if.master  memory bus
module mem_unit #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          we,
  input  logic [1:0]    sz,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   st_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [63:0]   ld_data,
  mem_unit_if.master    bus
);

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;

  // Latched command fields. Only what later beats still need is kept: the
  // first beat's bus fields are computed straight from the inputs at capture.
  logic        we_q;
  logic [1:0]  sz_q;
  logic [1:0]  lane_q;
  logic [31:0] st_hi_q;

  // Registered bus outputs.
  logic          req_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [3:0]    mem_be_q;
  logic [31:0]   mem_wdata_q;

  // Byte accesses may sit anywhere; words need 4-byte alignment and
  // doublewords 8-byte alignment. The reserved size is never legal.
  function automatic logic cmd_legal(input logic [1:0] s, input logic [2:0] a);
    logic ok;
    case (s)
      SZ_BYTE:  ok = 1'b1;
      SZ_WORD:  ok = (a[1:0] == 2'b00);
      SZ_DWORD: ok = (a == 3'b000);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

  // A byte touches only its own lane; word and doubleword beats use all four.
  function automatic logic [3:0] byte_enable(input logic [1:0] s, input logic [1:0] lane);
    logic [3:0] be;
    if (s == SZ_BYTE) begin
      be = 4'b0001 << lane;
    end else begin
      be = 4'b1111;
    end
    return be;
  endfunction

  // The store byte is replicated on every lane so the enabled lane always
  // carries it, whichever lane that is.
  function automatic logic [31:0] first_wdata(input logic [1:0] s, input logic [31:0] d);
    logic [31:0] w;
    if (s == SZ_BYTE) begin
      w = {4{d[7:0]}};
    end else begin
      w = d;
    end
    return w;
  endfunction

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;

  // Command FSM with all outputs registered alongside the state. Bus fields
  // are loaded on the transition into a beat and held until mem_ack, then
  // cleared when the command leaves the bus so IDLE and DONE show all zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      sz_q        <= 2'b00;
      lane_q      <= 2'b00;
      st_hi_q     <= 32'h0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      ld_data     <= 64'h0;
      req_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            we_q    <= we;
            sz_q    <= sz;
            lane_q  <= addr[1:0];
            st_hi_q <= st_data[63:32];
            busy    <= 1'b1;
            if (cmd_legal(sz, addr[2:0])) begin
              state       <= BEAT0;
              req_q       <= 1'b1;
              mem_we_q    <= we;
              mem_addr_q  <= {addr[AW-1:2], 2'b00};
              mem_be_q    <= byte_enable(sz, addr[1:0]);
              mem_wdata_q <= first_wdata(sz, st_data[31:0]);
            end else begin
              // Illegal commands finish straight away and never touch the bus.
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end
          end
        end

        BEAT0: begin
          if (bus.mem_ack) begin
            if (!we_q) begin
              case (sz_q)
                SZ_BYTE:  ld_data <= {56'h0, bus.mem_rdata[{lane_q, 3'b000} +: 8]};
                SZ_WORD:  ld_data <= {32'h0, bus.mem_rdata};
                default:  ld_data[31:0] <= bus.mem_rdata;
              endcase
            end
            if (sz_q == SZ_DWORD) begin
              // Second beat: next word, upper half of the store data.
              state       <= BEAT1;
              mem_addr_q  <= mem_addr_q + AW'(4);
              mem_wdata_q <= st_hi_q;
            end else begin
              state       <= DONE;
              done        <= 1'b1;
              req_q       <= 1'b0;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= '0;
              mem_be_q    <= 4'b0000;
              mem_wdata_q <= 32'h0;
            end
          end
        end

        BEAT1: begin
          if (bus.mem_ack) begin
            if (!we_q) begin
              ld_data[63:32] <= bus.mem_rdata;
            end
            state       <= DONE;
            done        <= 1'b1;
            req_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0;
          end
        end

        DONE: begin
          // A start seen here is dropped; the next accept is one cycle later.
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_unit.md
# mem_unit

Load/store unit of the CPU data path. It accepts one load or store command at a time and runs it on a 32-bit handshaked data-memory bus. Doubleword accesses are split into two beats. Load data is returned as a raw, zero-extended 64-bit value for the writeback selector, which applies sign or zero extension for the 4-byte and 1-byte load opcodes.

## Interface
Parameters:
- AW, 32, memory byte-address width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  command strobe; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- sz  in  2  access size: 00 byte, 10 word (4 B), 11 doubleword (8 B), 01 reserved.
- addr  in  AW  byte address.
- st_data  in  64  store data; only the low 8 or 32 bits are used for byte and word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: misaligned access or reserved size.
- ld_data  out  64  load result; holds its value until the next load completes.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write enable.
- mem_addr  out  AW  bus address, always word-aligned (bits [1:0] = 0).
- mem_be  out  4  byte enables; bit i enables lane i, bits [8i+7:8i].
- mem_wdata  out  32  bus write data.
- mem_ack  in  1  beat accepted; read data valid in the same cycle.
- mem_rdata  in  32  bus read data.

## Operation
- Command capture: on start in IDLE, latch we, sz, addr and st_data. Inputs are ignored in every other state.
- States:
  - IDLE: on start, go to BEAT0 if the command is legal, else go to DONE with err=1. An illegal command issues no bus request.
  - BEAT0: mem_req=1. On mem_ack, go to BEAT1 if sz=11, else go to DONE.
  - BEAT1: mem_req=1. On mem_ack, go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Legality:
  - sz=00: any address.
  - sz=10: addr[1:0]=0.
  - sz=11: addr[2:0]=0.
  - sz=01: always illegal.
- Bus fields:
  - mem_addr = {addr[AW-1:2],2'b00}; BEAT1 adds 4.
  - mem_we = latched we.
  - mem_be: byte uses 1<<addr[1:0]; word and doubleword use 1111.
- Store data:
  - byte: mem_wdata = {4{st_data[7:0]}}.
  - word: st_data[31:0].
  - doubleword: BEAT0 drives st_data[31:0], BEAT1 drives st_data[63:32].
- Load data, little-endian:
  - byte: ld_data = {56'b0, lane addr[1:0] of mem_rdata}.
  - word: {32'b0, mem_rdata}.
  - doubleword: BEAT0 rdata goes to [31:0], BEAT1 rdata goes to [63:32].
- ld_data update rules:
  - ld_data is registered and updates only on an acked load beat.
  - For a doubleword load, the [31:0] half is written at the BEAT0 ack, before done.
  - Stores and errored commands leave ld_data unchanged.
- Bus hold: mem_req stays high and mem_addr, mem_be, mem_wdata and mem_we stay stable until mem_ack. Any number of wait cycles is allowed.
- Idle outputs: mem_req is never high in IDLE or DONE; all bus outputs are 0 there.
- err: held low except in the DONE cycle of an illegal command.

## Timing
- Reset values: state IDLE; busy, done, err, mem_req, mem_we = 0; mem_addr, mem_be, mem_wdata, ld_data = 0.
- Reset mid-operation: an asserted rst_n clears everything immediately and the in-flight beat is abandoned. The bus must tolerate the request dropping.
- Zero-wait bus (mem_ack high in the same cycle as mem_req), start at cycle 0:
  - byte/word: req in cycle 1, done in cycle 2.
  - doubleword: req in cycles 1 and 2, done in cycle 3.
- Illegal command: done=1 and err=1 in cycle 1; no request.
- Each mem_ack wait cycle adds one cycle of latency.
- Back-to-back commands: done is asserted in DONE, not IDLE, so a start coincident with done is ignored. The earliest next accept is the cycle after done; peak issue is one command per 3 cycles for byte/word.
- busy rises the cycle after the start is accepted and falls in the cycle after done.
- mem_ack while mem_req=0 is ignored.

## Test plan
- Byte load, addr=0x1002, mem_rdata=0x11223344 with zero-wait ack -> mem_addr=0x1000, mem_be=0100, done at cycle 2, ld_data=0x0000000000000022.
- Doubleword load, addr=0x2000, beats return 0xDEADBEEF then 0x01234567 -> mem_addr 0x2000 then 0x2004, ld_data=0x01234567DEADBEEF, done at cycle 3.
- Word store, addr=0x30, st_data=0xAABBCCDD with 3 wait cycles before ack -> req held with stable addr 0x30, be=1111, wdata=0xAABBCCDD; done 5 cycles after start; ld_data unchanged.
- Misaligned word (addr=0x31), doubleword at addr=0x44, and sz=01 -> each gives done+err in cycle 1 with mem_req never asserted.
- Byte store, addr=0x7, st_data low byte 0x5A -> be=1000, wdata=0x5A5A5A5A; a start pulsed during busy and during done is ignored.
- Doubleword load with rst_n asserted while in BEAT1 -> all outputs 0 immediately; after release, a new byte load completes normally.
